// File: rtl/lcd_hd44780_driver.sv
// Write-only HD44780 character-LCD controller: autonomous power-on init, then one
// command/data byte per valid/ready handshake with 8-bit bus timing and execution waits.
module lcd_hd44780_driver #(
    parameter int unsigned POWER_ON_CYCLES    = 375000,
    parameter int unsigned SETUP_CYCLES       = 2,
    parameter int unsigned E_HIGH_CYCLES      = 12,
    parameter int unsigned HOLD_CYCLES        = 2,
    parameter int unsigned SHORT_DELAY_CYCLES = 1000,
    parameter int unsigned LONG_DELAY_CYCLES  = 41000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);

    localparam int unsigned Max0 = (POWER_ON_CYCLES > SETUP_CYCLES) ? POWER_ON_CYCLES
                                                                    : SETUP_CYCLES;
    localparam int unsigned Max1 = (Max0 > E_HIGH_CYCLES) ? Max0 : E_HIGH_CYCLES;
    localparam int unsigned Max2 = (Max1 > HOLD_CYCLES) ? Max1 : HOLD_CYCLES;
    localparam int unsigned Max3 = (Max2 > SHORT_DELAY_CYCLES) ? Max2 : SHORT_DELAY_CYCLES;
    localparam int unsigned MaxCycles = (Max3 > LONG_DELAY_CYCLES) ? Max3 : LONG_DELAY_CYCLES;
    localparam int unsigned CntW = $clog2(MaxCycles + 1);

    localparam logic [CntW-1:0] PowerLast = CntW'(POWER_ON_CYCLES - 1);
    localparam logic [CntW-1:0] SetupLast = CntW'(SETUP_CYCLES - 1);
    localparam logic [CntW-1:0] PulseLast = CntW'(E_HIGH_CYCLES - 1);
    localparam logic [CntW-1:0] HoldLast  = CntW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] ShortLast = CntW'(SHORT_DELAY_CYCLES - 1);
    localparam logic [CntW-1:0] LongLast  = CntW'(LONG_DELAY_CYCLES - 1);
    localparam logic [2:0]      InitLast  = 3'd5;

    typedef enum logic [2:0] {
        StPowerWait,
        StSetup,
        StPulse,
        StHold,
        StDelay,
        StIdle
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic            rs_q, rs_d;
    logic [7:0]      data_q, data_d;
    logic            e_q, e_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic            long_sel;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: init_byte = 8'h38;
            3'd3:             init_byte = 8'h0C;
            3'd4:             init_byte = 8'h01;
            default:          init_byte = 8'h06;
        endcase
    endfunction

    // Clear (0x01), home (0x02/0x03) and 0x00 need the long execution wait.
    assign long_sel = !rs_q && (data_q[7:2] == 6'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StPowerWait;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StPowerWait: if (cnt_q == PowerLast) state_d = StSetup;
            StSetup:     if (cnt_q == '0) state_d = StPulse;
            StPulse:     if (cnt_q == '0) state_d = StHold;
            StHold:      if (cnt_q == '0) state_d = StDelay;
            StDelay: begin
                if (cnt_q == '0) begin
                    state_d = (done_q || idx_q == InitLast) ? StIdle : StSetup;
                end
            end
            StIdle:      if (req_valid) state_d = StSetup;
            default:     state_d = StPowerWait;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        rs_d   = rs_q;
        data_d = data_q;
        // Power-on wait counts up from the reset-cleared value; all other states count down.
        if (state_q == StPowerWait) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
        if (state_d != state_q) begin
            unique case (state_d)
                StSetup: begin
                    cnt_d = SetupLast;
                    if (state_q == StIdle) begin
                        rs_d   = req_rs;
                        data_d = req_data;
                    end else begin
                        if (state_q == StDelay) idx_d = idx_q + 3'd1;
                        rs_d   = 1'b0;
                        data_d = init_byte(idx_d);
                    end
                end
                StPulse:     cnt_d = PulseLast;
                StHold:      cnt_d = HoldLast;
                StDelay:     cnt_d = long_sel ? LongLast : ShortLast;
                StIdle:      cnt_d = '0;
                StPowerWait: cnt_d = '0;
                default:     cnt_d = '0;
            endcase
        end
        e_d     = (state_d == StPulse);
        ready_d = (state_d == StIdle);
        done_d  = done_q | (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            rs_q    <= 1'b0;
            data_q  <= '0;
            e_q     <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            e_q     <= e_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign req_ready = ready_q;
    assign init_done = done_q;
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_e     = e_q;
    assign lcd_data  = data_q;

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
// Directed bench for lcd_hd44780_driver: a bus monitor pops expected bytes from a
// scoreboard on every E rise, and the main sequence checks handshake and init timing.
module tb_lcd_hd44780_driver;

    localparam int unsigned P  = 100;
    localparam int unsigned S  = 2;
    localparam int unsigned E  = 4;
    localparam int unsigned H  = 2;
    localparam int unsigned SH = 10;
    localparam int unsigned LG = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready;
    logic       init_done;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;

    lcd_hd44780_driver #(
        .POWER_ON_CYCLES   (P),
        .SETUP_CYCLES      (S),
        .E_HIGH_CYCLES     (E),
        .HOLD_CYCLES       (H),
        .SHORT_DELAY_CYCLES(SH),
        .LONG_DELAY_CYCLES (LG)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_rs   (req_rs),
        .req_data (req_data),
        .init_done(init_done),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_e    (lcd_e),
        .lcd_data (lcd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];
    int rise_q[$];
    int pulses = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_init();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h006);
    endtask

    // Bus monitor, sampled on the falling edge.
    logic       e_prev = 1'b0;
    logic [8:0] bus_prev = 9'h000;
    logic [8:0] bus_exp;
    int         rise_c = 0;
    int         fall_c = -100;
    int         chg_c = -100;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                e_prev   = 1'b0;
                bus_prev = 9'h000;
                fall_c   = -100;
                chg_c    = -100;
            end else begin
                if ({lcd_rs, lcd_data} != bus_prev) begin
                    check("bus_change_with_e_low", {30'd0, e_prev, lcd_e}, 32'd0);
                    check("hold_after_fall", {31'd0, (cyc - fall_c) >= int'(H)}, 32'd1);
                    chg_c = cyc;
                end
                if (lcd_e && !e_prev) begin
                    pulses++;
                    rise_c = cyc;
                    rise_q.push_back(cyc);
                    check("setup_before_rise", {31'd0, (cyc - chg_c) >= int'(S)}, 32'd1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse", {23'd0, lcd_rs, lcd_data}, 32'h1ff);
                    end else begin
                        bus_exp = exp_q.pop_front();
                        check("pulse_bus", {23'd0, lcd_rs, lcd_data}, {23'd0, bus_exp});
                    end
                end
                if (!lcd_e && e_prev) begin
                    check("e_width", cyc - rise_c, E);
                    fall_c = cyc;
                end
                e_prev   = lcd_e;
                bus_prev = {lcd_rs, lcd_data};
            end
        end
    end

    // Called just after a falling edge; returns the accept edge and the ready-low cycle count.
    task automatic send(input logic rs, input logic [7:0] d, input bit keep,
                        output int acc, output int low);
        int n;
        n = 0;
        while (!req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("ready_timeout", {31'd0, req_ready}, 32'd1);
        req_rs    = rs;
        req_data  = d;
        req_valid = 1'b1;
        exp_q.push_back({rs, d});
        acc = cyc + 1;
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
        check("ready_drop", {31'd0, req_ready}, 32'd0);
        low = 0;
        while (!req_ready && low < 1000) begin
            low++;
            @(negedge clk);
        end
    endtask

    int rel;
    int n;
    int acc;
    int low;
    int accs[3];
    int p0;
    int exp_gap[5] = '{18, 18, 18, 18, 58};

    initial begin
        // Reset with a request already pending: it must not be taken during init.
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h55;
        repeat (3) @(negedge clk);
        check("rst_e", {31'd0, lcd_e}, 32'd0);
        check("rst_rs", {31'd0, lcd_rs}, 32'd0);
        check("rst_rw", {31'd0, lcd_rw}, 32'd0);
        check("rst_data", {24'd0, lcd_data}, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_done", {31'd0, init_done}, 32'd0);

        push_init();
        rise_q.delete();
        pulses = 0;
        rst_n  = 1'b1;
        rel    = cyc;
        n = 0;
        while (!req_ready && n < 1000) begin
            check("done_before_ready", {31'd0, init_done}, 32'd0);
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        check("init_ready_time", cyc - rel, 248);
        check("init_done_with_ready", {31'd0, init_done}, 32'd1);
        check("init_pulses", pulses, 6);
        check("init_queue_empty", exp_q.size(), 0);
        if (rise_q.size() == 6) begin
            check("init_first_rise", rise_q[0] - rel, P + S);
            for (int i = 0; i < 5; i++) begin
                check("init_gap", rise_q[i+1] - rise_q[i], exp_gap[i]);
            end
        end else begin
            check("init_rise_count", rise_q.size(), 6);
        end

        // Single data byte.
        rise_q.delete();
        send(1'b1, 8'h41, 1'b0, acc, low);
        check("data_ready_low", low, 18);
        check("data_rise_after_accept", (rise_q.size() > 0) ? rise_q[0] - acc : -1, S);
        check("data_bus_kept", {23'd0, lcd_rs, lcd_data}, 32'h141);
        check("done_stays", {31'd0, init_done}, 32'd1);

        // Clear then set-DDRAM: long then short execution.
        send(1'b0, 8'h01, 1'b0, acc, low);
        check("clear_ready_low", low, 58);
        send(1'b0, 8'h80, 1'b0, acc, low);
        check("ddram_ready_low", low, 18);

        // Back-to-back with valid held high.
        p0 = pulses;
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 8'h30 + 8'(i), (i < 2), acc, low);
            accs[i] = acc;
        end
        check("b2b_period_0", accs[1] - accs[0], 19);
        check("b2b_period_1", accs[2] - accs[1], 19);
        check("b2b_pulses", pulses - p0, 3);

        // Reset while E is high.
        req_rs    = 1'b1;
        req_data  = 8'h55;
        req_valid = 1'b1;
        exp_q.push_back(9'h155);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!lcd_e && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("e_seen_before_reset", {31'd0, lcd_e}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_e", {31'd0, lcd_e}, 32'd0);
        check("midrst_bus", {23'd0, lcd_rs, lcd_data}, 32'd0);
        check("midrst_ready_done", {30'd0, req_ready, init_done}, 32'd0);
        @(negedge clk);
        push_init();
        rise_q.delete();
        rst_n = 1'b1;
        rel   = cyc;
        n = 0;
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("reinit_first_rise", (rise_q.size() > 0) ? rise_q[0] - rel : -1, P + S);
        check("reinit_ready_time", cyc - rel, 248);
        check("reinit_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_hd44780_driver.md
# lcd_hd44780_driver

Write-only HD44780 character-LCD controller between the Niski core's memory-mapped LCD register and the board pins `LCD_RS_PIN`, `LCD_RW_PIN`, `LCD_E_PIN` and `LCD_DATA_PINS`.

- After reset it runs the power-on initialisation sequence autonomously.
- It then accepts one command or data byte at a time over a valid/ready handshake.
- For each byte it generates 8-bit-mode bus timing (RS setup, E pulse, hold) and waits the controller's execution time before accepting the next byte.

## Interface
Parameters (all in `clk` cycles; defaults for 25 MHz):
- `POWER_ON_CYCLES`, 375000: wait from reset release to the first init command (15 ms).
- `SETUP_CYCLES`, 2: RS/data valid before the E rise (≥ 40 ns).
- `E_HIGH_CYCLES`, 12: E high width (≥ 450 ns).
- `HOLD_CYCLES`, 2: RS/data held after the E fall, with E low.
- `SHORT_DELAY_CYCLES`, 1000: execution wait for normal commands and data (40 µs).
- `LONG_DELAY_CYCLES`, 41000: execution wait for clear/home (1.64 ms).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: byte request.
- `req_ready` out 1: block can accept a byte.
- `req_rs` in 1: 0 = instruction, 1 = data.
- `req_data` in 8: byte to write.
- `init_done` out 1: the init sequence has completed; stays high until reset.
- `lcd_rs` out 1: register select.
- `lcd_rw` out 1: constant 0 (write only).
- `lcd_e` out 1: enable strobe.
- `lcd_data` out 8: data bus.

## Operation
- FSM states:
  - `POWER_WAIT`: counts up to `POWER_ON_CYCLES`.
  - `SETUP`: drives RS/data with E low.
  - `PULSE`: E high.
  - `HOLD`: E low, RS/data still driven.
  - `DELAY`: execution wait.
  - `IDLE`: ready for the next byte.
- Init ROM, 6 instruction bytes (RS = 0), sent in order: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
  - A 3-bit index advances after each `DELAY`.
  - After the 6th `DELAY` the FSM enters `IDLE` and `init_done` goes to 1.
- Transfer accept: `req_valid & req_ready` at a rising edge.
  - `req_rs` and `req_data` are captured into holding registers.
  - The FSM enters `SETUP`.
- Delay select: `LONG_DELAY_CYCLES` when RS = 0 and `data[7:2] == 0` (clear 0x01, home 0x02/0x03); `SHORT_DELAY_CYCLES` otherwise.
  - Byte 0x00 with RS = 0 also takes the long delay.
  - All data writes (RS = 1) take the short delay.
- Handshake rules:
  - `req_ready` = (state == `IDLE`), driven from a register.
  - `req_valid` while ready is low has no effect; the requester holds its request until accepted.
  - `req_rs`/`req_data` are sampled only at the accept edge.
- Counter: one shared down-counter, sized with `$clog2` of the largest parameter. It is loaded with N−1 on state entry, and the state exits on the edge where the counter is 0.
- `lcd_rs`/`lcd_data` are registered. They keep the last byte after `HOLD` and change only at entry to `SETUP`.
- Reset:
  - While `rst_n` = 0: `lcd_e`, `lcd_rs`, `lcd_rw`, `lcd_data`, `req_ready` and `init_done` are all 0, and the FSM is in `POWER_WAIT` with the counter cleared.
  - Reset during any state, including mid-E-pulse, drops E immediately (asynchronously) and restarts the full init on release.

## Timing
- Per byte, counting from entry to `SETUP` at edge t:
  - `lcd_e` rises at t+S.
  - `lcd_e` falls at t+S+E.
  - `DELAY` is entered at t+S+E+H.
  - `IDLE` is entered (`req_ready` = 1) at t+S+E+H+D.
- Byte latency from the accept edge to `req_ready` high again = S+E+H+D cycles.
- Back-to-back: a new accept is possible on the first `IDLE` edge, so the minimum byte period is S+E+H+D+1 cycles.
- Init:
  - The first `SETUP` is entered `POWER_ON_CYCLES` edges after reset release.
  - Init takes 6·(S+E+H) + 5·SHORT + LONG further cycles.
  - `init_done` and `req_ready` rise together.
- Exactly one E pulse per byte. E is never high in `POWER_WAIT`, `DELAY`, `IDLE` or reset.

## Test plan
Test parameters: POWER_ON = 100, S = 2, E = 4, H = 2, SHORT = 10, LONG = 50.
- Reset, then release → `init_done` = `req_ready` = 0 until 248 cycles after release. Bus shows 6 E pulses with `lcd_data` 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 and `lcd_rs` = 0. The gap after the 0x01 pulse is 50 cycles; other gaps are 10 cycles.
- After init, send RS = 1, data 0x41 → `req_ready` is low for 18 cycles. E is high for exactly 4 cycles, starting 2 cycles after the accept. `lcd_rs` = 1 and `lcd_data` = 0x41 are stable from 2 cycles before E rises until 2 cycles after it falls.
- Send RS = 0, data 0x01, then RS = 0, data 0x80 → the ready gaps are 58 and 18 cycles.
- Hold `req_valid` = 1 with data 0x30, 0x31, 0x32 changing only on accepts → exactly 3 E pulses, with accept edges 19 cycles apart.
- Hold `req_valid` high during init → no accept and no extra E pulse before `init_done`.
- Assert `rst_n` = 0 while E is high → E = 0 and all outputs are 0 immediately. After release the init sequence restarts from 0x38 following 100 cycles.
